// File: rtl/encode_aluop_pkg.sv
// encode_aluop_pkg: shared constants and types for the decode-stage ALU-op encoder.
// Holds opcode values, ALU operation codes, instruction field positions and
// the packed decode result carried from the combinational decoder to the output register.
package encode_aluop_pkg;

  // Instruction field positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int RFUNC_MSB  = 6;
  localparam int RFUNC_LSB  = 2;

  // Primary opcodes, bits [31:27]
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BEX   = 5'b10101;
  localparam logic [4:0] OP_SETX  = 5'b10110;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // Decode result, one entry per instruction
  typedef struct packed {
    logic [4:0] alu_op;
    logic       uses_imm;
    logic       is_branch;
    logic       uses_alu;
  } dec_t;

  localparam dec_t DEC_NONE = '0;

endpackage

// File: rtl/encode_aluop_if.sv
// encode_aluop_if: bundles the instruction load side and the decoded result side.
// Ports: instruction[31:0], en (load enable) toward the encoder;
// alu_op[4:0], uses_imm, is_branch, uses_alu back from it.
interface encode_aluop_if;

  logic [31:0] instruction;
  logic        en;
  logic [4:0]  alu_op;
  logic        uses_imm;
  logic        is_branch;
  logic        uses_alu;

  // master: the decode-stage driver supplying instructions
  modport master (
    output instruction,
    output en,
    input  alu_op,
    input  uses_imm,
    input  is_branch,
    input  uses_alu
  );

  // slave: the encoder itself
  modport slave (
    input  instruction,
    input  en,
    output alu_op,
    output uses_imm,
    output is_branch,
    output uses_alu
  );

endinterface

// File: rtl/encode_aluop_decode_comb.sv
// aluop_decode_comb: maps an instruction word to {alu_op, uses_imm, is_branch, uses_alu}.
// Latency: 0 cycles (pure combinational); no backpressure.
// Ports: instruction[31:0] in, dec (packed dec_t) out. Only bits [31:27] and [6:2] matter.
module aluop_decode_comb
  import encode_aluop_pkg::*;
(
  input  logic [31:0] instruction,
  output dec_t        dec
);

  logic [4:0] opcode;
  logic [4:0] rfunc;
  logic       unused_bits;

  assign opcode = instruction[OPCODE_MSB:OPCODE_LSB];
  assign rfunc  = instruction[RFUNC_MSB:RFUNC_LSB];

  // Remaining fields carry registers/immediates that the ALU-op choice never looks at.
  assign unused_bits = ^{instruction[26:7], instruction[1:0]};

  always_comb begin
    dec = DEC_NONE;
    case (opcode)
      OP_RTYPE: begin
        // Function field goes straight through, including codes beyond ALU_DIV.
        dec.alu_op   = rfunc;
        dec.uses_alu = 1'b1;
      end
      OP_ADDI, OP_SW, OP_LW: begin
        // Address generation and add-immediate all add rs + sign-extended imm.
        dec.alu_op   = ALU_ADD;
        dec.uses_imm = 1'b1;
        dec.uses_alu = 1'b1;
      end
      OP_BNE, OP_BLT, OP_BEX: begin
        // Conditional branches compare by subtracting.
        dec.alu_op    = ALU_SUB;
        dec.is_branch = 1'b1;
        dec.uses_alu  = 1'b1;
      end
      default: begin
        // j, jal, jr, setx and unassigned opcodes never touch the ALU.
        dec = DEC_NONE;
      end
    endcase
  end

endmodule

// File: rtl/encode_aluop.sv
// encode_aluop: registered ALU-operation encoder for the decode stage.
// Latency: 1 cycle from an enabled rising edge; en low holds outputs, no other backpressure.
// Ports: clock, reset_n (async active-low, clears outputs to 0), bus (encode_aluop_if.slave).
module encode_aluop
  import encode_aluop_pkg::*;
(
  input  logic            clock,
  input  logic            reset_n,
  encode_aluop_if.slave   bus
);

  dec_t dec_nxt;
  dec_t dec_q;

  aluop_decode_comb u_decode (
    .instruction (bus.instruction),
    .dec         (dec_nxt)
  );

  // Async clear drops outputs immediately and discards any capture in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_q <= DEC_NONE;
    end else if (bus.en) begin
      dec_q <= dec_nxt;
    end
  end

  assign bus.alu_op    = dec_q.alu_op;
  assign bus.uses_imm  = dec_q.uses_imm;
  assign bus.is_branch = dec_q.is_branch;
  assign bus.uses_alu  = dec_q.uses_alu;

endmodule

// File: tb/tb_encode_aluop.sv
// tb_encode_aluop: directed-vector bench for encode_aluop.
// Observed outputs are packed as {alu_op[4:0], uses_imm, is_branch, uses_alu}.
module tb_encode_aluop;

  logic clock;
  logic reset_n;

  encode_aluop_if bus ();

  encode_aluop dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] obs;
  assign obs = {bus.alu_op, bus.uses_imm, bus.is_branch, bus.uses_alu};

  // Expected packed outputs, worked out by hand from the opcode table
  localparam logic [7:0] E_ZERO  = 8'b00000_000;
  localparam logic [7:0] E_BEEF  = 8'b11011_001; // R-type, [6:2] of 0xef = 11011
  localparam logic [7:0] E_IMM   = 8'b00000_101;
  localparam logic [7:0] E_BR    = 8'b00001_011;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a new instruction at the falling edge, away from the capture edge.
  task automatic drive(input logic [31:0] instr, input logic en_v);
    @(negedge clock);
    bus.instruction = instr;
    bus.en          = en_v;
  endtask

  task automatic after_edge();
    @(posedge clock);
    #1;
  endtask

  // Hand-filled sweep table: opcode -> expected outputs with low bits 0xbeef.
  logic [7:0] sweep_exp [32];

  initial begin
    for (int i = 0; i < 32; i++) sweep_exp[i] = E_ZERO;
    sweep_exp[0]  = E_BEEF; // R-type
    sweep_exp[2]  = E_BR;   // bne
    sweep_exp[5]  = E_IMM;  // addi
    sweep_exp[6]  = E_BR;   // blt
    sweep_exp[7]  = E_IMM;  // sw
    sweep_exp[8]  = E_IMM;  // lw
    sweep_exp[21] = E_BR;   // bex
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] instr;

    reset_n         = 1'b0;
    bus.instruction = 32'h0;
    bus.en          = 1'b0;

    // Reset state, and outputs stay clear through an enabled edge under reset
    #1;
    check_val("reset_init", {24'h0, obs}, {24'h0, E_ZERO});
    drive(32'h0000beef, 1'b1);
    after_edge();
    check_val("reset_hold_en", {24'h0, obs}, {24'h0, E_ZERO});

    // First capture on the first edge after release
    @(negedge clock);
    reset_n = 1'b1;
    after_edge();
    check_val("first_capture", {24'h0, obs}, {24'h0, E_BEEF});

    // Mid-cycle reset clears without a clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check_val("async_clear", {24'h0, obs}, {24'h0, E_ZERO});
    after_edge();
    check_val("reset_low_edge", {24'h0, obs}, {24'h0, E_ZERO});
    @(negedge clock);
    reset_n = 1'b1;
    after_edge();
    check_val("post_reset", {24'h0, obs}, {24'h0, E_BEEF});

    // Opcode sweep, one per cycle
    for (int op = 0; op < 32; op++) begin
      instr = {op[4:0], 27'h000beef};
      drive(instr, 1'b1);
      after_edge();
      check_val($sformatf("sweep_op%0d", op), {24'h0, obs}, {24'h0, sweep_exp[op]});
    end

    // R-type pass-through
    drive(32'h00000004, 1'b1);
    after_edge();
    check_val("rtype_sub", {27'h0, bus.alu_op}, 32'h01);
    drive(32'h0000001c, 1'b1);
    after_edge();
    check_val("rtype_div", {27'h0, bus.alu_op}, 32'h07);
    for (int k = 0; k < 6; k++) begin
      rnd   = $urandom;
      instr = {5'b00000, rnd[19:0], 5'b00001, rnd[21:20]};
      drive(instr, 1'b1);
      after_edge();
      check_val($sformatf("rtype_rand%0d", k), {24'h0, obs}, {24'h0, 8'b00001_001});
    end

    // Enable hold
    drive(32'h2800beef, 1'b1);
    after_edge();
    check_val("hold_load", {24'h0, obs}, {24'h0, E_IMM});
    for (int k = 0; k < 3; k++) begin
      drive(32'h1000beef, 1'b0);
      after_edge();
      check_val($sformatf("hold_cyc%0d", k), {24'h0, obs}, {24'h0, E_IMM});
    end

    // Back-to-back alternation: before each edge the previous result is still shown,
    // right after it the newly driven instruction appears.
    drive(32'h0000beef, 1'b1);
    after_edge();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        drive(32'h1000beef, 1'b1);
        #1;
        check_val($sformatf("b2b_pre%0d", k), {27'h0, bus.alu_op}, 32'h1b);
        after_edge();
        check_val($sformatf("b2b_post%0d", k), {27'h0, bus.alu_op}, 32'h01);
      end else begin
        drive(32'h0000beef, 1'b1);
        #1;
        check_val($sformatf("b2b_pre%0d", k), {27'h0, bus.alu_op}, 32'h01);
        after_edge();
        check_val($sformatf("b2b_post%0d", k), {27'h0, bus.alu_op}, 32'h1b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
